// File: rtl/inst_fetch_unit_if.sv
// Fetch-to-decode handshake: the fetch unit presents {pc, inst} at the FIFO head,
// and the IF/ID stage takes it by raising ready.
interface inst_fetch_unit_if;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;

    modport master (output out_valid, output out_inst, output out_pc, input out_ready);
    modport slave  (input out_valid, input out_inst, input out_pc, output out_ready);
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: PC register, one-word-per-cycle fetch from a
// combinational instruction memory into a 2-entry prefetch FIFO, with redirects
// and an ECALL halt.
module inst_fetch_unit #(
    parameter int          ADDR_W   = 6,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic [31:0]         imem_data,
    input  logic                redirect_valid,
    input  logic [31:0]         redirect_pc,
    inst_fetch_unit_if.master   fetch,
    output logic                halted,
    output logic                misalign
);

    localparam logic [31:0] ECALL = 32'h0000_0073;

    logic [31:0]       pc_q;
    logic [1:0][31:0]  fifo_pc;
    logic [1:0][31:0]  fifo_inst;
    logic              head;
    logic              tail;
    logic [1:0]        count;
    logic              pop;
    logic              push;

    // The memory index is just the word part of the PC; it wraps naturally.
    assign imem_addr       = pc_q[ADDR_W+1:2];
    assign fetch.out_valid = (count != 2'd0);
    assign fetch.out_inst  = fifo_inst[head];
    assign fetch.out_pc    = fifo_pc[head];

    // Handshake decode; a redirect suppresses both sides so the flush wins.
    always_comb begin
        pop  = fetch.out_valid & fetch.out_ready & ~redirect_valid;
        push = ~halted & ~redirect_valid & ((count != 2'd2) | pop);
    end

    // PC, FIFO storage/pointers, halt and misalign flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q      <= {RESET_PC[31:2], 2'b00};
            fifo_pc   <= '0;
            fifo_inst <= '0;
            head      <= 1'b0;
            tail      <= 1'b0;
            count     <= 2'd0;
            halted    <= 1'b0;
            misalign  <= 1'b0;
        end else if (redirect_valid) begin
            // Flush: queued words belong to the abandoned path.
            pc_q   <= {redirect_pc[31:2], 2'b00};
            head   <= 1'b0;
            tail   <= 1'b0;
            count  <= 2'd0;
            halted <= 1'b0;
            if (redirect_pc[1:0] != 2'b00)
                misalign <= 1'b1;
        end else begin
            if (push) begin
                fifo_pc[tail]   <= pc_q;
                fifo_inst[tail] <= imem_data;
                tail            <= ~tail;
                pc_q            <= pc_q + 32'd4;
                // The ECALL itself is still queued; only later fetches stop.
                if (imem_data == ECALL)
                    halted <= 1'b1;
            end
            if (pop)
                head <= ~head;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed scenarios followed by random traffic.
// The expected delivery stream is rebuilt from memory contents whenever fetch
// restarts (reset release or redirect); a negedge monitor pops it on every
// accepted handshake.
module tb_inst_fetch_unit;

    localparam logic [31:0] ECALL    = 32'h0000_0073;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halted;
    logic        misalign;
    logic [31:0] mem [64];

    inst_fetch_unit_if bus();

    inst_fetch_unit #(.ADDR_W(6), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch          (bus),
        .halted         (halted),
        .misalign       (misalign)
    );

    assign imem_data = mem[imem_addr];

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_err = 0;
    ent_t exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected program-order stream from a start PC: consecutive words until an
    // ECALL (inclusive); 64 entries is more than any segment can consume.
    function automatic void fill(input logic [31:0] start);
        logic [31:0] p;
        logic [31:0] w;
        exp_q.delete();
        p = {start[31:2], 2'b00};
        for (int i = 0; i < 64; i++) begin
            w = mem[p[7:2]];
            exp_q.push_back('{pc: p, inst: w});
            if (w == ECALL) break;
            p = p + 32'd4;
        end
    endfunction

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Monitor: scoreboard pops on accepted handshakes and checks head stability.
    bit          hold = 1'b0;
    logic [31:0] hpc, hinst;
    ent_t        e;
    always @(negedge clk) begin
        if (rst_n) begin
            if (hold) begin
                chk("hold_valid", bus.out_valid, 1'b1);
                chk("hold_pc", bus.out_pc, hpc);
                chk("hold_inst", bus.out_inst, hinst);
            end
            if (bus.out_valid && bus.out_ready && !redirect_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL extra_delivery: got pc %h expected none", bus.out_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_pc", bus.out_pc, e.pc);
                    chk("sb_inst", bus.out_inst, e.inst);
                end
            end
            hold  = bus.out_valid && !bus.out_ready && !redirect_valid;
            hpc   = bus.out_pc;
            hinst = bus.out_inst;
        end else begin
            hold = 1'b0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          seg;
        bit          exp_mis;
        logic [31:0] rp;

        for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0093 | (i << 20);
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        bus.out_ready  = 1'b1;

        // 1: reset values, then pc 0,4,8,12 back to back
        nxt(); nxt();
        chk("rst_valid", bus.out_valid, 1'b0);
        chk("rst_pc", bus.out_pc, 32'h0);
        chk("rst_inst", bus.out_inst, 32'h0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_misalign", misalign, 1'b0);
        chk("rst_imem_addr", imem_addr, 6'd0);
        rst_n = 1'b1;
        fill(RESET_PC);
        for (int i = 0; i < 4; i++) begin
            nxt();
            chk("t1_valid", bus.out_valid, 1'b1);
            chk("t1_pc", bus.out_pc, 32'(i * 4));
        end

        // 2: stall 5 cycles, FIFO saturates at 2, then drain in order
        rst_n = 1'b0; bus.out_ready = 1'b0;
        nxt();
        rst_n = 1'b1;
        fill(RESET_PC);
        for (int i = 0; i < 5; i++) begin
            nxt();
            chk("t2_valid", bus.out_valid, 1'b1);
            chk("t2_head_pc", bus.out_pc, 32'h0);
        end
        chk("t2_imem_addr", imem_addr, 6'd2);
        bus.out_ready = 1'b1;
        nxt();
        chk("t2_pc4", bus.out_pc, 32'h4);
        nxt();
        chk("t2_pc8", bus.out_pc, 32'h8);

        // 3: redirect to 0x20 with two entries queued
        bus.out_ready = 1'b0;
        nxt(); nxt();
        redirect_valid = 1'b1; redirect_pc = 32'h20;
        fill(32'h20);
        nxt();
        redirect_valid = 1'b0;
        chk("t3_flush_valid", bus.out_valid, 1'b0);
        nxt();
        chk("t3_valid", bus.out_valid, 1'b1);
        chk("t3_pc", bus.out_pc, 32'h20);
        chk("t3_inst", bus.out_inst, mem[8]);
        bus.out_ready = 1'b1;
        repeat (4) nxt();

        // 4: ECALL at word 2 halts fetch; redirect to 0 resumes
        mem[2] = ECALL;
        rst_n  = 1'b0;
        nxt();
        rst_n = 1'b1;
        fill(RESET_PC);
        repeat (6) nxt();
        chk("t4_halted", halted, 1'b1);
        chk("t4_valid", bus.out_valid, 1'b0);
        redirect_valid = 1'b1; redirect_pc = 32'h0;
        fill(32'h0);
        nxt();
        redirect_valid = 1'b0;
        chk("t4_unhalt", halted, 1'b0);
        nxt();
        chk("t4_resume_valid", bus.out_valid, 1'b1);
        chk("t4_resume_pc", bus.out_pc, 32'h0);
        repeat (5) nxt();

        // 5: misaligned redirect with address wrap, then reset mid-stream
        rst_n  = 1'b0;
        mem[2] = 32'h0000_0093 | (2 << 20);
        nxt();
        rst_n = 1'b1;
        fill(RESET_PC);
        nxt(); nxt();
        redirect_valid = 1'b1; redirect_pc = 32'h102;
        fill(32'h102);
        nxt();
        redirect_valid = 1'b0;
        chk("t5_misalign", misalign, 1'b1);
        chk("t5_imem_addr", imem_addr, 6'd0);
        repeat (3) nxt();
        chk("t5_valid", bus.out_valid, 1'b1);
        chk("t5_pc_pre", bus.out_pc[31:8], 24'h1);
        rst_n = 1'b0;
        nxt();
        chk("t5_rst_valid", bus.out_valid, 1'b0);
        chk("t5_rst_pc", bus.out_pc, 32'h0);
        chk("t5_rst_inst", bus.out_inst, 32'h0);
        chk("t5_rst_halted", halted, 1'b0);
        chk("t5_rst_misalign", misalign, 1'b0);
        chk("t5_rst_imem_addr", imem_addr, 6'd0);

        // Random traffic: random memory with sprinkled ECALLs, random ready,
        // redirects (aligned and not) and occasional resets.
        for (int i = 0; i < 64; i++)
            mem[i] = ($urandom_range(0, 11) == 0) ? ECALL : $urandom;
        seg     = 0;
        exp_mis = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            redirect_valid = 1'b0;
            bus.out_ready  = ($urandom_range(0, 3) != 0);
            if (!rst_n) begin
                rst_n = 1'b1;
                fill(RESET_PC);
                seg = 0;
            end else if ($urandom_range(0, 299) == 0) begin
                rst_n   = 1'b0;
                exp_mis = 1'b0;
            end else if (seg > 40 || $urandom_range(0, 15) == 0) begin
                rp             = $urandom;
                redirect_valid = 1'b1;
                redirect_pc    = rp;
                fill(rp);
                if (rp[1:0] != 2'b00) exp_mis = 1'b1;
                seg = 0;
            end else begin
                seg++;
            end
            nxt();
        end
        redirect_valid = 1'b0;
        nxt();
        chk("rand_misalign", misalign, exp_mis);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
